// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM state encoding, queue entry layout and
// default sizing.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_WIDTH  = 8;
    localparam int unsigned FETCH_INSTR_WIDTH = 32;
    localparam int unsigned FETCH_QUEUE_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FULL,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_INSTR_WIDTH-1:0] instr;
        logic [FETCH_ADDR_WIDTH-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle of the fetch stage: instruction-memory req/ack, execute redirect and the decode
// valid/ready channel. The predictor hint signals exist only when FETCH_BPU_HINT_EN is defined.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned INSTR_WIDTH = 32
);

    logic                   imem_req_o;
    logic [ADDR_WIDTH-1:0]  imem_addr_o;
    logic                   imem_ack_i;
    logic [INSTR_WIDTH-1:0] imem_data_i;
    logic                   redirect_i;
    logic [ADDR_WIDTH-1:0]  redirect_pc_i;
    logic                   inst_valid_o;
    logic                   inst_ready_i;
    logic [INSTR_WIDTH-1:0] inst_o;
    logic [ADDR_WIDTH-1:0]  inst_pc_o;
`ifdef FETCH_BPU_HINT_EN
    logic                   bpu_taken_i;
    logic [ADDR_WIDTH-1:0]  bpu_target_i;
`endif

    // Fetch unit side
    modport master (
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        input  imem_ack_i, imem_data_i, redirect_i, redirect_pc_i,
`ifdef FETCH_BPU_HINT_EN
        input  bpu_taken_i, bpu_target_i,
`endif
        input  inst_ready_i
    );

    // Memory / execute / decode side
    modport slave (
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        output imem_ack_i, imem_data_i, redirect_i, redirect_pc_i,
`ifdef FETCH_BPU_HINT_EN
        output bpu_taken_i, bpu_target_i,
`endif
        output inst_ready_i
    );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {instr, pc} entries with push, pop and flush. DEPTH must be a
// power of two so the read/write pointers wrap naturally.
module fetch_queue import fetch_pkg::*; #(
    parameter type         entry_t = fetch_entry_t,
    parameter int unsigned DEPTH   = FETCH_QUEUE_DEPTH,
    localparam int unsigned CntW   = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            push_i,
    input  entry_t          entry_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output entry_t          head_o,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    entry_t            mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              push_do, pop_do;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer / occupancy next state; pop on empty and push on full are ignored, flush wins
    always_comb begin
        push_do  = push_i && !full_o;
        pop_do   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_do) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop_do)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push_do && !pop_do)      count_d = count_q + CntW'(1);
            else if (pop_do && !push_do) count_d = count_q - CntW'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while not counted as occupied
    always_ff @(posedge clk_i) begin
        if (push_do && !flush_i) mem_q[wr_ptr_q] <= entry_i;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one outstanding instruction-memory read at a time, buffers
// returned words in fetch_queue and hands them to decode. Redirects from execute flush the queue.
// Optional FETCH_BPU_HINT_EN: a taken predictor hint on an accepted fetch replaces pc+1.
module instr_fetch_unit import fetch_pkg::*; #(
    parameter int unsigned           ADDR_WIDTH  = FETCH_ADDR_WIDTH,
    parameter int unsigned           INSTR_WIDTH = FETCH_INSTR_WIDTH,
    parameter int unsigned           QUEUE_DEPTH = FETCH_QUEUE_DEPTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    instr_fetch_unit_if.master    bus
);

    localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  pc;
    } entry_t;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] drop_addr_q, drop_addr_d;  // address of the request being discarded
    logic                  push, pop, flush, ack;
    entry_t                head, entry_in;
    logic [CntW-1:0]       q_count;
    logic                  q_full, q_empty;

    fetch_queue #(
        .entry_t (entry_t),
        .DEPTH   (QUEUE_DEPTH)
    ) u_queue (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .push_i  (push),
        .entry_i (entry_in),
        .pop_i   (pop),
        .flush_i (flush),
        .head_o  (head),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign entry_in = '{instr: bus.imem_data_i, pc: pc_q};

    // Decode channel: head is zeroed while the queue is empty
    always_comb begin
        bus.inst_valid_o = !q_empty;
        bus.inst_o       = q_empty ? '0 : head.instr;
        bus.inst_pc_o    = q_empty ? '0 : head.pc;
        pop              = !q_empty && bus.inst_ready_i;
    end

    // Fetch FSM next state, PC update and memory request outputs; redirect overrides all
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        drop_addr_d     = drop_addr_q;
        push            = 1'b0;
        flush           = 1'b0;
        bus.imem_req_o  = 1'b0;
        bus.imem_addr_o = (state_q == DROP) ? drop_addr_q : pc_q;
        ack             = 1'b0;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                bus.imem_req_o = 1'b1;
                ack            = bus.imem_ack_i;
                if (ack) begin
                    push = !q_full;
                    pc_d = pc_q + ADDR_WIDTH'(1);
`ifdef FETCH_BPU_HINT_EN
                    if (bus.bpu_taken_i) pc_d = bus.bpu_target_i;
`endif
                    // Last free slot taken with nothing leaving: stop requesting
                    if (q_count == CntW'(QUEUE_DEPTH - 1) && !pop) state_d = FULL;
                end
            end
            FULL: if (pop) state_d = REQ;
            DROP: begin
                bus.imem_req_o = 1'b1;
                ack            = bus.imem_ack_i;
                if (ack) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
        if (bus.redirect_i) begin
            flush = 1'b1;
            push  = 1'b0;
            pc_d  = bus.redirect_pc_i;
            if (state_q == REQ && !ack) begin
                state_d     = DROP;
                drop_addr_d = pc_q;
            end else if (state_q == DROP && !ack) begin
                state_d = DROP;
            end else begin
                state_d = REQ;
            end
        end
    end

    // State, PC and drop-address registers
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, queue fill/backpressure, PC wrap,
// redirect with late ack, redirect colliding with ack and pop, and optional predictor hint.
module tb_instr_fetch_unit;

    logic clk;
    logic arst;
    int   n_pass;
    int   n_total;

    instr_fetch_unit_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(32)) bus ();

    instr_fetch_unit #(
        .ADDR_WIDTH  (8),
        .INSTR_WIDTH (32),
        .QUEUE_DEPTH (4),
        .RESET_PC    (8'h00)
    ) dut (
        .clk_i  (clk),
        .arst_i (arst),
        .bus    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content: every word encodes its own address
    function automatic logic [31:0] mk(input logic [7:0] a);
        return {24'hC0DE5A, a};
    endfunction

    assign bus.imem_data_i = mk(bus.imem_addr_o);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        arst              = 1'b1;
        bus.imem_ack_i    = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 8'h00;
        bus.inst_ready_i  = 1'b0;
`ifdef FETCH_BPU_HINT_EN
        bus.bpu_taken_i   = 1'b0;
        bus.bpu_target_i  = 8'h00;
`endif
        step();
        step();
        arst = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        arst    = 1'b1;

        // Reset values
        do_reset();
        arst = 1'b1;
        step();
        check_eq("rst_req",   32'(bus.imem_req_o),   32'd0);
        check_eq("rst_addr",  32'(bus.imem_addr_o),  32'd0);
        check_eq("rst_valid", 32'(bus.inst_valid_o), 32'd0);
        check_eq("rst_inst",  bus.inst_o,            32'd0);
        check_eq("rst_pc",    32'(bus.inst_pc_o),    32'd0);

        // 1: streaming fetch, head trails ack by one cycle
        do_reset();
        bus.imem_ack_i   = 1'b1;
        bus.inst_ready_i = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            check_eq("t1_req",  32'(bus.imem_req_o),  32'd1);
            check_eq("t1_addr", 32'(bus.imem_addr_o), 32'(i));
            if (i == 0) begin
                check_eq("t1_valid0", 32'(bus.inst_valid_o), 32'd0);
            end else begin
                check_eq("t1_valid", 32'(bus.inst_valid_o), 32'd1);
                check_eq("t1_ipc",   32'(bus.inst_pc_o),    32'(i - 1));
                check_eq("t1_inst",  bus.inst_o,            mk(8'(i - 1)));
            end
            step();
        end

        // 2: backpressure fills 4 entries, then one pop resumes fetch at pc 4
        do_reset();
        bus.imem_ack_i = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check_eq("t2_full_req", 32'(bus.imem_req_o),   32'd0);
        check_eq("t2_valid",    32'(bus.inst_valid_o), 32'd1);
        check_eq("t2_head",     32'(bus.inst_pc_o),    32'd0);
        step();
        check_eq("t2_hold_req", 32'(bus.imem_req_o), 32'd0);
        bus.inst_ready_i = 1'b1;
        step();
        bus.inst_ready_i = 1'b0;
        check_eq("t2_resume_req",  32'(bus.imem_req_o),  32'd1);
        check_eq("t2_resume_addr", 32'(bus.imem_addr_o), 32'd4);
        check_eq("t2_head_next",   32'(bus.inst_pc_o),   32'd1);

        // 3: address wrap 0xFE, 0xFF, 0x00
        do_reset();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 8'hFE;
        step();
        bus.redirect_i   = 1'b0;
        bus.imem_ack_i   = 1'b1;
        bus.inst_ready_i = 1'b1;
        check_eq("t3_addr_fe", 32'(bus.imem_addr_o), 32'hFE);
        step();
        check_eq("t3_addr_ff", 32'(bus.imem_addr_o), 32'hFF);
        check_eq("t3_ipc_fe",  32'(bus.inst_pc_o),   32'hFE);
        step();
        check_eq("t3_addr_00", 32'(bus.imem_addr_o), 32'h00);
        check_eq("t3_ipc_ff",  32'(bus.inst_pc_o),   32'hFF);
        step();
        check_eq("t3_ipc_00",  32'(bus.inst_pc_o),   32'h00);
        check_eq("t3_inst_00", bus.inst_o,           mk(8'h00));

        // 4: redirect while a request is pending, ack arrives late
        do_reset();
        bus.inst_ready_i = 1'b1;
        step();
        check_eq("t4_addr0", 32'(bus.imem_addr_o), 32'd0);
        step();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 8'h40;
        step();
        bus.redirect_i = 1'b0;
        check_eq("t4_drop_req",   32'(bus.imem_req_o),   32'd1);
        check_eq("t4_drop_addr",  32'(bus.imem_addr_o),  32'd0);
        check_eq("t4_drop_valid", 32'(bus.inst_valid_o), 32'd0);
        step();
        check_eq("t4_drop_addr2", 32'(bus.imem_addr_o), 32'd0);
        bus.imem_ack_i = 1'b1;
        step();
        check_eq("t4_stale_valid", 32'(bus.inst_valid_o), 32'd0);
        check_eq("t4_new_addr",    32'(bus.imem_addr_o),  32'h40);
        step();
        check_eq("t4_valid", 32'(bus.inst_valid_o), 32'd1);
        check_eq("t4_ipc",   32'(bus.inst_pc_o),    32'h40);
        check_eq("t4_inst",  bus.inst_o,            mk(8'h40));

        // 5: redirect in the same cycle as ack and pop
        do_reset();
        bus.imem_ack_i   = 1'b1;
        bus.inst_ready_i = 1'b1;
        step();
        step();
        check_eq("t5_pre_valid", 32'(bus.inst_valid_o), 32'd1);
        check_eq("t5_pre_addr",  32'(bus.imem_addr_o),  32'd1);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 8'h80;
        step();
        bus.redirect_i = 1'b0;
        bus.imem_ack_i = 1'b0;
        check_eq("t5_flush_valid", 32'(bus.inst_valid_o), 32'd0);
        check_eq("t5_req",         32'(bus.imem_req_o),   32'd1);
        check_eq("t5_addr",        32'(bus.imem_addr_o),  32'h80);
        bus.imem_ack_i = 1'b1;
        step();
        check_eq("t5_ipc", 32'(bus.inst_pc_o), 32'h80);

        // 6: predictor hint (or strictly sequential when the hint is compiled out)
        do_reset();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 8'h03;
        step();
        bus.redirect_i   = 1'b0;
        bus.imem_ack_i   = 1'b1;
        bus.inst_ready_i = 1'b1;
        check_eq("t6_addr_a", 32'(bus.imem_addr_o), 32'h03);
`ifdef FETCH_BPU_HINT_EN
        bus.bpu_taken_i  = 1'b1;
        bus.bpu_target_i = 8'h10;
        step();
        bus.bpu_taken_i  = 1'b0;
        check_eq("t6_addr_b", 32'(bus.imem_addr_o), 32'h10);
        step();
        check_eq("t6_addr_c", 32'(bus.imem_addr_o), 32'h11);
`else
        step();
        check_eq("t6_addr_b", 32'(bus.imem_addr_o), 32'h04);
        step();
        check_eq("t6_addr_c", 32'(bus.imem_addr_o), 32'h05);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
